// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its scheduler.
// Opcode/operand/address types plus scheduler bundles.
package instr_register_pkg;

   typedef enum logic [3:0] {
      ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD
   } opcode_t;

   typedef logic signed [31:0] operand_t;
   typedef logic [4:0]         address_t;

   localparam int REG_DEPTH = 2 ** $bits(address_t);

   typedef logic [5:0] sched_count_t;

   typedef struct packed {
      opcode_t  opc;
      operand_t op_a;
      operand_t op_b;
   } instr_req_t;

endpackage

// File: rtl/instr_reg_sched_rr_arbiter.sv
// Round-robin arbiter with one-hot grant.
// Search starts one past the last granted index.
module rr_arbiter #(
   parameter int N = 2
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic [N-1:0] req,
   input  logic         advance,
   output logic [N-1:0] gnt
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;

   logic [IW-1:0] last;
   logic [IW-1:0] win;
   logic [IW:0]   cand;
   logic [IW-1:0] idx;
   logic          found;

   // Pick the first requester after the last grant, wrapping at N
   always_comb begin
      gnt   = '0;
      win   = last;
      found = 1'b0;
      cand  = '0;
      idx   = '0;
      for (int i = 1; i <= N; i++) begin
         cand = {1'b0, last} + (IW+1)'(i);
         if (cand >= (IW+1)'(N))
            cand = cand - (IW+1)'(N);
         idx = cand[IW-1:0];
         if (!found && req[idx]) begin
            gnt[idx] = 1'b1;
            win      = idx;
            found    = 1'b1;
         end
      end
   end

   // Remember the winner only when a grant is actually taken
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         last <= IW'(N - 1);
      else if (advance && found)
         last <= win;
   end

endmodule

// File: rtl/instr_reg_sched.sv
// Write/read sequencer for the 32-entry instruction register.
// Arbitrates producers onto the load port; reads in order.
module instr_reg_sched
   import instr_register_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int DEPTH   = 32
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   flush,
   input  logic [NUM_REQ-1:0]     req_valid,
   output logic [NUM_REQ-1:0]     req_ready,
   input  opcode_t                req_opcode    [NUM_REQ],
   input  operand_t               req_operand_a [NUM_REQ],
   input  operand_t               req_operand_b [NUM_REQ],
   output logic                   load_en,
   output opcode_t                opcode,
   output operand_t               operand_a,
   output operand_t               operand_b,
   output address_t               write_pointer,
   output address_t               read_pointer,
   output logic                   rd_valid,
   input  logic                   rd_ready,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);

   localparam int CW = $clog2(DEPTH) + 1;

   typedef logic [CW-1:0] cnt_t;

   logic [CW:0]          occ;
   logic                 accept;
   logic [NUM_REQ-1:0]   arb_req;
   logic                 grant;
   logic                 pop;
   instr_req_t           win_req;
   address_t             wr_ptr;
   cnt_t                 count_n;

   // Occupancy includes the load in flight; pops are not credited
   assign occ    = {1'b0, count} + {{CW{1'b0}}, load_en};
   assign accept = reset_n && !flush && (occ < (CW+1)'(DEPTH));
   assign arb_req = accept ? req_valid : '0;
   assign grant  = |req_ready;

   assign rd_valid = !empty;
   assign pop      = rd_valid && rd_ready;

   rr_arbiter #(
      .N(NUM_REQ)
   ) u_arb (
      .clk     (clk),
      .reset_n (reset_n),
      .req     (arb_req),
      .advance (grant),
      .gnt     (req_ready)
   );

   // Mux the granted producer's instruction
   always_comb begin
      win_req = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (req_ready[i]) begin
            win_req.opc  = req_opcode[i];
            win_req.op_a = req_operand_a[i];
            win_req.op_b = req_operand_b[i];
         end
      end
   end

   // Load stage: register the winner for a write one cycle later
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         load_en       <= 1'b0;
         opcode        <= ZERO;
         operand_a     <= '0;
         operand_b     <= '0;
         write_pointer <= '0;
         wr_ptr        <= '0;
      end else if (flush) begin
         load_en       <= 1'b0;
         write_pointer <= '0;
         wr_ptr        <= '0;
      end else begin
         load_en <= grant;
         if (grant) begin
            opcode        <= win_req.opc;
            operand_a     <= win_req.op_a;
            operand_b     <= win_req.op_b;
            write_pointer <= wr_ptr;
            wr_ptr        <= wr_ptr + 1'b1;
         end
      end
   end

   // Next occupancy from landing loads and pops
   always_comb begin
      count_n = count;
      unique case ({load_en, pop})
         2'b10:   count_n = count + 1'b1;
         2'b01:   count_n = count - 1'b1;
         default: count_n = count;
      endcase
   end

   // Queue state: occupancy, read pointer and registered flags
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count        <= '0;
         read_pointer <= '0;
         empty        <= 1'b1;
         full         <= 1'b0;
      end else if (flush) begin
         count        <= '0;
         read_pointer <= '0;
         empty        <= 1'b1;
         full         <= 1'b0;
      end else begin
         count <= count_n;
         if (pop)
            read_pointer <= read_pointer + 1'b1;
         empty <= (count_n == '0);
         full  <= (count_n == cnt_t'(DEPTH));
      end
   end

   ap_onehot : assert property (
      @(posedge clk) disable iff (!reset_n) $onehot0(req_ready));

   ap_no_grant_full : assert property (
      @(posedge clk) disable iff (!reset_n)
      (occ == (CW+1)'(DEPTH)) |-> !grant);

   ap_count_max : assert property (
      @(posedge clk) disable iff (!reset_n) count <= cnt_t'(DEPTH));

endmodule

// File: tb/tb_instr_reg_sched.sv
// Directed bench for instr_reg_sched.
// One task per scenario with inline comparisons.
module tb_instr_reg_sched;
   import instr_register_pkg::*;

   localparam int NR = 2;

   logic         clk;
   logic         reset_n;
   logic         flush;
   logic [NR-1:0] req_valid;
   logic [NR-1:0] req_ready;
   opcode_t      req_opcode    [NR];
   operand_t     req_operand_a [NR];
   operand_t     req_operand_b [NR];
   logic         load_en;
   opcode_t      opcode;
   operand_t     operand_a;
   operand_t     operand_b;
   address_t     write_pointer;
   address_t     read_pointer;
   logic         rd_valid;
   logic         rd_ready;
   logic [5:0]   count;
   logic         full;
   logic         empty;

   int errors = 0;
   int checks = 0;

   instr_reg_sched #(.NUM_REQ(NR), .DEPTH(32)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .flush         (flush),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_opcode    (req_opcode),
      .req_operand_a (req_operand_a),
      .req_operand_b (req_operand_b),
      .load_en       (load_en),
      .opcode        (opcode),
      .operand_a     (operand_a),
      .operand_b     (operand_b),
      .write_pointer (write_pointer),
      .read_pointer  (read_pointer),
      .rd_valid      (rd_valid),
      .rd_ready      (rd_ready),
      .count         (count),
      .full          (full),
      .empty         (empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cleanup();
      req_valid = '0;
      rd_ready  = 1'b0;
      flush     = 1'b1;
      step();
      flush = 1'b0;
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if ({load_en, full, rd_valid, req_ready} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctl got le=%0b f=%0b rv=%0b rr=%b exp 0",
                  load_en, full, rd_valid, req_ready);
      end
      checks++;
      if (count !== 6'd0 || empty !== 1'b1) begin
         errors++;
         $display("FAIL reset_cnt got count=%0d empty=%0b exp 0/1", count, empty);
      end
      checks++;
      if (write_pointer !== 5'd0 || read_pointer !== 5'd0 || opcode !== ZERO) begin
         errors++;
         $display("FAIL reset_ptr got wp=%0d rp=%0d opc=%0d exp 0/0/0",
                  write_pointer, read_pointer, opcode);
      end
      @(negedge clk);
      reset_n = 1'b1;
      step();
   endtask

   task automatic test_round_robin();
      req_opcode[0] = ADD; req_operand_a[0] = 1;  req_operand_b[0] = 2;
      req_opcode[1] = SUB; req_operand_a[1] = 10; req_operand_b[1] = 20;
      req_valid = 2'b11;
      #1;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (req_ready !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
            errors++;
            $display("FAIL rr_grant%0d got %b exp %b", i, req_ready,
                     (i % 2 == 0) ? 2'b01 : 2'b10);
         end
         step();
         if (i == 3) req_valid = '0;
         checks++;
         if (load_en !== 1'b1 || write_pointer !== address_t'(i) ||
             opcode !== ((i % 2 == 0) ? ADD : SUB)) begin
            errors++;
            $display("FAIL rr_load%0d got le=%0b wp=%0d opc=%0d exp 1/%0d/%0d",
                     i, load_en, write_pointer, opcode, i,
                     (i % 2 == 0) ? ADD : SUB);
         end
      end
      step();
      checks++;
      if (count !== 6'd4) begin
         errors++;
         $display("FAIL rr_count got %0d exp 4", count);
      end
      cleanup();
   endtask

   task automatic test_single();
      req_opcode[0] = ADD; req_operand_a[0] = 5; req_operand_b[0] = 3;
      req_valid = 2'b01;
      #1;
      checks++;
      if (req_ready !== 2'b01) begin
         errors++;
         $display("FAIL single_grant got %b exp 01", req_ready);
      end
      step();
      req_valid = '0;
      checks++;
      if (load_en !== 1'b1 || write_pointer !== 5'd0 || opcode !== ADD ||
          operand_a !== 5 || operand_b !== 3) begin
         errors++;
         $display("FAIL single_load got le=%0b wp=%0d opc=%0d a=%0d b=%0d exp 1/0/3/5/3",
                  load_en, write_pointer, opcode, operand_a, operand_b);
      end
      checks++;
      if (count !== 6'd0 || rd_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_early got count=%0d rv=%0b exp 0/0", count, rd_valid);
      end
      step();
      checks++;
      if (count !== 6'd1 || rd_valid !== 1'b1 || load_en !== 1'b0) begin
         errors++;
         $display("FAIL single_ready got count=%0d rv=%0b le=%0b exp 1/1/0",
                  count, rd_valid, load_en);
      end
      rd_ready = 1'b1;
      step();
      rd_ready = 1'b0;
      checks++;
      if (count !== 6'd0 || empty !== 1'b1 || read_pointer !== 5'd1) begin
         errors++;
         $display("FAIL single_pop got count=%0d empty=%0b rp=%0d exp 0/1/1",
                  count, empty, read_pointer);
      end
      cleanup();
   endtask

   task automatic test_fill();
      int n;
      n = 0;
      req_opcode[0] = MULT;
      req_valid = 2'b01;
      #1;
      for (int k = 0; k < 40; k++) begin
         if (req_ready[0]) n++;
         step();
      end
      checks++;
      if (n != 32) begin
         errors++;
         $display("FAIL fill_grants got %0d exp 32", n);
      end
      checks++;
      if (full !== 1'b1 || count !== 6'd32 || empty !== 1'b0) begin
         errors++;
         $display("FAIL fill_full got full=%0b count=%0d empty=%0b exp 1/32/0",
                  full, count, empty);
      end
      checks++;
      if (req_ready !== 2'b00) begin
         errors++;
         $display("FAIL fill_block got %b exp 00", req_ready);
      end
      rd_ready = 1'b1;
      step();
      rd_ready = 1'b0;
      #1;
      checks++;
      if (full !== 1'b0 || count !== 6'd31 || req_ready !== 2'b01) begin
         errors++;
         $display("FAIL fill_pop got full=%0b count=%0d rr=%b exp 0/31/01",
                  full, count, req_ready);
      end
      step();
      req_valid = '0;
      checks++;
      if (load_en !== 1'b1 || write_pointer !== 5'd0 || read_pointer !== 5'd1) begin
         errors++;
         $display("FAIL fill_wrap got le=%0b wp=%0d rp=%0d exp 1/0/1",
                  load_en, write_pointer, read_pointer);
      end
      cleanup();
   endtask

   task automatic test_steady();
      req_opcode[0] = PASSA;
      req_valid = 2'b01;
      rd_ready  = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         step();
         if (k >= 2) begin
            checks++;
            if (count !== 6'd1 || write_pointer !== address_t'((k - 1) % 32) ||
                read_pointer !== address_t'((k - 2) % 32)) begin
               errors++;
               $display("FAIL steady%0d got count=%0d wp=%0d rp=%0d exp 1/%0d/%0d",
                        k, count, write_pointer, read_pointer,
                        (k - 1) % 32, (k - 2) % 32);
            end
         end
      end
      cleanup();
   endtask

   task automatic test_flush();
      req_opcode[0] = DIV;
      req_valid = 2'b01;
      step();
      step();
      step();
      flush = 1'b1;
      #1;
      checks++;
      if (req_ready !== 2'b00 || load_en !== 1'b1 || count !== 6'd2 ||
          write_pointer !== 5'd2) begin
         errors++;
         $display("FAIL flush_pre got rr=%b le=%0b count=%0d wp=%0d exp 00/1/2/2",
                  req_ready, load_en, count, write_pointer);
      end
      step();
      flush     = 1'b0;
      req_valid = '0;
      checks++;
      if (count !== 6'd0 || write_pointer !== 5'd0 || read_pointer !== 5'd0 ||
          load_en !== 1'b0 || empty !== 1'b1) begin
         errors++;
         $display("FAIL flush_post got count=%0d wp=%0d rp=%0d le=%0b empty=%0b exp 0/0/0/0/1",
                  count, write_pointer, read_pointer, load_en, empty);
      end
      step();
      step();
      checks++;
      if (count !== 6'd0 || rd_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_drop got count=%0d rv=%0b exp 0/0", count, rd_valid);
      end
   endtask

   task automatic test_async_reset();
      req_opcode[0] = ADD;
      req_opcode[1] = SUB;
      req_valid = 2'b11;
      step();
      step();
      checks++;
      if (req_ready !== 2'b10) begin
         errors++;
         $display("FAIL areset_pre got %b exp 10", req_ready);
      end
      #3;
      reset_n = 1'b0;
      #1;
      checks++;
      if (load_en !== 1'b0 || count !== 6'd0 || write_pointer !== 5'd0 ||
          empty !== 1'b1 || full !== 1'b0 || rd_valid !== 1'b0 ||
          req_ready !== 2'b00 || opcode !== ZERO) begin
         errors++;
         $display("FAIL areset_now got le=%0b count=%0d wp=%0d e=%0b f=%0b rv=%0b rr=%b opc=%0d",
                  load_en, count, write_pointer, empty, full, rd_valid,
                  req_ready, opcode);
      end
      #2;
      reset_n = 1'b1;
      #1;
      checks++;
      if (req_ready !== 2'b01) begin
         errors++;
         $display("FAIL areset_first got %b exp 01", req_ready);
      end
      step();
      req_valid = '0;
      checks++;
      if (load_en !== 1'b1 || write_pointer !== 5'd0 || opcode !== ADD) begin
         errors++;
         $display("FAIL areset_load got le=%0b wp=%0d opc=%0d exp 1/0/3",
                  load_en, write_pointer, opcode);
      end
   endtask

   initial begin
      reset_n   = 1'b0;
      flush     = 1'b0;
      rd_ready  = 1'b0;
      req_valid = '0;
      for (int i = 0; i < NR; i++) begin
         req_opcode[i]    = ZERO;
         req_operand_a[i] = 0;
         req_operand_b[i] = 0;
      end
      test_reset();
      test_round_robin();
      test_single();
      test_fill();
      test_steady();
      test_flush();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
